uart_sample_deframer: RTL

UART_SAMPLE_DEFRAMER -- requirements
Module: uart_sample_deframer

---
 rtl/uart_sample_deframer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_sample_deframer.sv
// Deframes A5/LO/HI byte frames from a UART receiver into a sample FIFO drained at a fixed tick.
// Optional trailing XOR checksum byte when DEFRAMER_CHECKSUM_EN is defined.
module uart_sample_deframer #(
    parameter int CLK_FREQ    = 10_000_000,
    parameter int SAMPLE_RATE = 48000,
    parameter int FIFO_AW     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     rx_error,
    output logic                     rx_ack,
    output logic signed [15:0]       sample,
    output logic                     sample_valid,
    output logic [FIFO_AW:0]         fifo_level,
    output logic                     overflow,
    output logic                     underrun,
    output logic [7:0]               sync_errs,
    input  logic                     clr_flags
);

    localparam int PERIOD = CLK_FREQ / SAMPLE_RATE;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int LVL_W  = FIFO_AW + 1;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
`ifdef DEFRAMER_CHECKSUM_EN
    localparam logic [1:0] ST_CHK  = 2'd3;
`endif

    logic [1:0]              state_q, state_d;
    logic                    ack_q, ack_d;
    logic                    armed_q, armed_d;
    logic                    consume;
    logic                    err_evt;
    logic [7:0]              lo_q, lo_d;
`ifdef DEFRAMER_CHECKSUM_EN
    logic [7:0]              hi_q, hi_d;
`endif
    logic                    push_q, push_d;
    logic signed [15:0]      push_data_q, push_data_d;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tick;

    logic signed [15:0]      mem [DEPTH];
    logic [LVL_W-1:0]        wr_q, wr_d;
    logic [LVL_W-1:0]        rd_q, rd_d;
    logic [LVL_W-1:0]        level;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    logic signed [15:0]      sample_q, sample_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    overflow_q, overflow_d;
    logic                    underrun_q, underrun_d;
    logic [7:0]              sync_errs_q, sync_errs_d;

    // A byte is taken only after rx_ready has been seen low since the previous
    // take, so a receiver that is slow to drop its level cannot be read twice.
    assign consume = rx_ready && !ack_q && armed_q;
    assign ack_d   = consume;
    assign armed_d = consume ? 1'b0 : (armed_q | ~rx_ready);

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
`ifdef DEFRAMER_CHECKSUM_EN
        hi_d        = hi_q;
`endif
        push_d      = 1'b0;
        push_data_d = push_data_q;
        err_evt     = 1'b0;
        if (consume) begin
            if (rx_error) begin
                state_d = ST_HUNT;
                err_evt = (state_q != ST_HUNT);
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_d = ST_LO;
                        end
                    end
                    ST_LO: begin
                        lo_d    = rx_data;
                        state_d = ST_HI;
                    end
                    ST_HI: begin
`ifdef DEFRAMER_CHECKSUM_EN
                        hi_d    = rx_data;
                        state_d = ST_CHK;
`else
                        push_d      = 1'b1;
                        push_data_d = {rx_data, lo_q};
                        state_d     = ST_HUNT;
`endif
                    end
`ifdef DEFRAMER_CHECKSUM_EN
                    ST_CHK: begin
                        if (rx_data == (SYNC_BYTE ^ lo_q ^ hi_q)) begin
                            push_d      = 1'b1;
                            push_data_d = {hi_q, lo_q};
                        end else begin
                            err_evt = 1'b1;
                        end
                        state_d = ST_HUNT;
                    end
`endif
                    default: state_d = ST_HUNT;
                endcase
            end
        end
    end

    // Sample tick
    assign tick  = (cnt_q == CNT_W'(PERIOD - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // FIFO bookkeeping; pop is evaluated first so a full FIFO can accept a push
    assign level   = wr_q - rd_q;
    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop     = tick && !empty;
    assign push_ok = push_q && (!full || pop);
    assign drop    = push_q && full && !pop;
    assign wr_d    = wr_q + LVL_W'(push_ok);
    assign rd_d    = rd_q + LVL_W'(pop);

    assign sample_d       = pop ? mem[rd_q[FIFO_AW-1:0]] : sample_q;
    assign sample_valid_d = tick;

    always_comb begin
        overflow_d  = overflow_q | drop;
        underrun_d  = underrun_q | (tick && empty);
        sync_errs_d = sync_errs_q;
        if (err_evt && (sync_errs_q != ERR_MAX)) begin
            sync_errs_d = sync_errs_q + 8'd1;
        end
        if (clr_flags) begin
            overflow_d  = 1'b0;
            underrun_d  = 1'b0;
            sync_errs_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_HUNT;
            ack_q          <= 1'b0;
            armed_q        <= 1'b1;
            push_q         <= 1'b0;
            cnt_q          <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            underrun_q     <= 1'b0;
            sync_errs_q    <= '0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            armed_q        <= armed_d;
            push_q         <= push_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overflow_q     <= overflow_d;
            underrun_q     <= underrun_d;
            sync_errs_q    <= sync_errs_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by control state
    always_ff @(posedge clk) begin
        lo_q        <= lo_d;
`ifdef DEFRAMER_CHECKSUM_EN
        hi_q        <= hi_d;
`endif
        push_data_q <= push_data_d;
        if (push_ok) begin
            mem[wr_q[FIFO_AW-1:0]] <= push_data_q;
        end
    end

    assign rx_ack       = ack_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign fifo_level   = level;
    assign overflow     = overflow_q;
    assign underrun     = underrun_q;
    assign sync_errs    = sync_errs_q;

endmodule
